// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: memory command encodings,
// fetch FSM states and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: holds its value unless load_en is set, then takes
// either pc+1 (wrapping modulo 2^AW) or the redirect target.
module fetch_pc_reg #(
  parameter int unsigned     AW       = 9,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic          sel_redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Next PC: hold, increment or redirect.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      if (sel_redirect) pc_d = redirect_pc;
      else              pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // PC register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and instruction register, reads
// memory with a ready handshake and hands instructions to decode.
//
// Handshakes: a memory read is in flight while mem_cmd=MREAD and completes in
// the cycle mem_ready=1 (mem_rdata captured on that edge). An instruction is
// offered while instr_valid=1 and is consumed on the edge where instr_ready=1.
// redirect wins over every other input and discards any held instruction.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned   AW       = 9,
  parameter int unsigned   DW       = 16,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC),
  parameter int unsigned   MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic [AW-1:0] pc_out,
  output logic          halted,
  output logic          fetch_err,
  output fetch_state_t  state_dbg
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  fetch_state_t  state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          fetch_err_q, fetch_err_d;
  logic          pc_load;
  logic          pc_sel_redirect;
  logic [AW-1:0] pc;

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .load_en      (pc_load),
    .sel_redirect (pc_sel_redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc)
  );

  // Next-state logic; redirect overrides everything once out of RST.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    ir_d            = ir_q;
    fetch_err_d     = fetch_err_q;
    pc_load         = 1'b0;
    pc_sel_redirect = 1'b0;
    if (redirect && (state_q != RST)) begin
      state_d         = FETCH;
      wait_cnt_d      = '0;
      fetch_err_d     = 1'b0;
      pc_load         = 1'b1;
      pc_sel_redirect = 1'b1;
    end else begin
      case (state_q)
        RST: state_d = FETCH;
        FETCH: begin
          if (mem_ready) begin
            ir_d       = mem_rdata;
            pc_load    = 1'b1;
            wait_cnt_d = '0;
            state_d    = HOLD;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            fetch_err_d = 1'b1;
            wait_cnt_d  = '0;
            state_d     = HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (instr_ready) state_d = halt ? HALT : FETCH;
        end
        HALT:    state_d = HALT;
        default: state_d = RST;
      endcase
    end
  end

  // State, wait counter, instruction register and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST;
      wait_cnt_q  <= '0;
      ir_q        <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ir_q        <= ir_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Moore outputs decoded from registered state only.
  assign mem_cmd     = (state_q == FETCH) ? MREAD : MNONE;
  assign mem_addr    = pc;
  assign pc_out      = pc;
  assign instr       = ir_q;
  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALT);
  assign fetch_err   = fetch_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, an async-reset sequence and
// randomized traffic compared against a behavioural model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int MW = 4;

  logic         clk;
  logic         reset;
  logic [1:0]   mem_cmd;
  logic [8:0]   mem_addr;
  logic [15:0]  mem_rdata;
  logic         mem_ready;
  logic [15:0]  instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [8:0]   redirect_pc;
  logic         halt;
  logic [8:0]   pc_out;
  logic         halted;
  logic         fetch_err;
  fetch_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.AW(9), .DW(16), .RESET_PC(9'h000), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_cmd     (mem_cmd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc_out      (pc_out),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [8:0] a);
    return 16'hC0A5 ^ {a, 7'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch unit is doing, in plain terms.
  bit          m_started, m_busy, m_holding, m_stopped, m_err;
  logic [8:0]  m_pc;
  logic [15:0] m_ir;
  int          m_waits;

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_holding = 0; m_stopped = 0; m_err = 0;
    m_pc = 9'h000; m_ir = 16'h0000; m_waits = 0;
  endtask

  task automatic model_edge(input bit rdy, input bit ird, input bit hlt,
                            input bit rdr, input logic [8:0] rpc);
    if (!m_started) begin
      m_started = 1; m_busy = 1;
    end else if (rdr) begin
      m_pc = rpc; m_err = 0; m_busy = 1; m_holding = 0; m_stopped = 0; m_waits = 0;
    end else if (m_busy) begin
      if (rdy) begin
        m_ir = mem_word(m_pc); m_pc = m_pc + 9'd1;
        m_busy = 0; m_holding = 1; m_waits = 0;
      end else if (m_waits == MW) begin
        m_err = 1; m_busy = 0; m_stopped = 1; m_waits = 0;
      end else begin
        m_waits++;
      end
    end else if (m_holding && ird) begin
      m_holding = 0;
      if (hlt) m_stopped = 1;
      else     m_busy = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mem_cmd"}, 32'(mem_cmd), m_busy ? 32'd1 : 32'd0);
    if (m_busy) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_pc));
    chk({tag, ".pc_out"}, 32'(pc_out), 32'(m_pc));
    chk({tag, ".instr"}, 32'(instr), 32'(m_ir));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_holding));
    chk({tag, ".halted"}, 32'(halted), 32'(m_stopped));
    chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
  endtask

  // Driver: apply inputs, clock once, advance model, compare outputs.
  task automatic drive(input bit rdy, input bit ird, input bit hlt,
                       input bit rdr, input logic [8:0] rpc);
    mem_ready = rdy; instr_ready = ird; halt = hlt; redirect = rdr; redirect_pc = rpc;
    mem_rdata = (mem_cmd == MREAD) ? mem_word(mem_addr) : 16'($urandom);
  endtask

  task automatic run_cycle(input string tag, input bit rdy, input bit ird, input bit hlt,
                           input bit rdr, input logic [8:0] rpc);
    drive(rdy, ird, hlt, rdr, rpc);
    @(posedge clk);
    model_edge(rdy, ird, hlt, rdr, rpc);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    chk("reset.state", 32'(state_dbg), 32'(RST));
    reset = 1'b1;
  endtask

  // Directed vectors: inputs before an edge, outputs expected after it.
  typedef struct {
    bit rdy; bit ird; bit hlt; bit rdr; logic [8:0] rpc;
    logic [1:0] cmd; logic [8:0] pc; bit vld; bit hto; bit err; logic [15:0] ins;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit rdy, bit ird, bit hlt, bit rdr, logic [8:0] rpc,
                             logic [1:0] cmd, logic [8:0] pc, bit vld, bit hto,
                             bit err, logic [15:0] ins);
    vec_t r;
    r.rdy = rdy; r.ird = ird; r.hlt = hlt; r.rdr = rdr; r.rpc = rpc;
    r.cmd = cmd; r.pc = pc; r.vld = vld; r.hto = hto; r.err = err; r.ins = ins;
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 9'h000);

    // Reset release, zero-wait fetch, 3 wait states
    tbl.push_back(v(0,1,0,0,9'h000, 2'd1, 9'h000, 0,0,0, 16'h0));
    tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h001, 1,0,0, mem_word(9'h000)));
    tbl.push_back(v(0,1,0,0,9'h000, 2'd1, 9'h001, 0,0,0, 16'h0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,0,0,9'h000, 2'd1, 9'h001, 0,0,0, 16'h0));
    tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h002, 1,0,0, mem_word(9'h001)));
    // Decoder stalls 5 cycles (mem_ready high is ignored outside FETCH)
    for (int i = 0; i < 5; i++) tbl.push_back(v(1,0,0,0,9'h000, 2'd0, 9'h002, 1,0,0, mem_word(9'h001)));
    tbl.push_back(v(0,1,0,0,9'h000, 2'd1, 9'h002, 0,0,0, 16'h0));
    tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h003, 1,0,0, mem_word(9'h002)));
    // Halt at acceptance, 10 idle cycles, redirect out
    tbl.push_back(v(0,1,1,0,9'h000, 2'd0, 9'h003, 0,1,0, 16'h0));
    for (int i = 0; i < 10; i++) tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h003, 0,1,0, 16'h0));
    tbl.push_back(v(0,1,0,1,9'h010, 2'd1, 9'h010, 0,0,0, 16'h0));
    tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h011, 1,0,0, mem_word(9'h010)));
    // Redirect beats acceptance in HOLD, then timeout after 5 FETCH cycles
    tbl.push_back(v(1,1,0,1,9'h040, 2'd1, 9'h040, 0,0,0, 16'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0,1,0,0,9'h000, 2'd1, 9'h040, 0,0,0, 16'h0));
    tbl.push_back(v(0,1,0,0,9'h000, 2'd0, 9'h040, 0,1,1, 16'h0));
    // Redirect clears error; fetch at 1FF wraps PC to 0
    tbl.push_back(v(0,1,0,1,9'h1FF, 2'd1, 9'h1FF, 0,0,0, 16'h0));
    tbl.push_back(v(1,1,0,0,9'h000, 2'd0, 9'h000, 1,0,0, mem_word(9'h1FF)));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].ird, tbl[i].hlt, tbl[i].rdr, tbl[i].rpc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.mem_cmd", i), 32'(mem_cmd), 32'(tbl[i].cmd));
      if (tbl[i].cmd == MREAD) chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].pc));
      chk($sformatf("vec%0d.pc_out", i), 32'(pc_out), 32'(tbl[i].pc));
      chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(tbl[i].hto));
      chk($sformatf("vec%0d.fetch_err", i), 32'(fetch_err), 32'(tbl[i].err));
      if (tbl[i].vld) chk($sformatf("vec%0d.instr", i), 32'(instr), 32'(tbl[i].ins));
    end

    // Asynchronous reset in the middle of a fetch
    do_reset();
    run_cycle("arst.f0", 0, 1, 0, 0, 9'h000);
    run_cycle("arst.f1", 0, 1, 0, 0, 9'h000);
    drive(1, 1, 0, 0, 9'h000);
    reset = 1'b0;
    #2;
    model_reset();
    check_model("arst.immediate");
    @(posedge clk);
    #1;
    check_model("arst.after_edge");
    reset = 1'b1;
    run_cycle("arst.restart", 0, 1, 0, 0, 9'h000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit rdy, ird, hlt, rdr;
      logic [8:0] rpc;
      rdy = ($urandom_range(0, 2) == 0);
      ird = ($urandom_range(0, 2) != 0);
      hlt = ($urandom_range(0, 7) == 0);
      rdr = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 9'h1FE + 9'($urandom_range(0, 1)) : 9'($urandom);
      run_cycle("rand", rdy, ird, hlt, rdr, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the multicycle CPU, replacing the fixed IF1/IF2/UpdatePC sequence and standalone 9-bit PC. It owns the program counter and instruction register. It fetches over a memory port with a ready handshake, so any number of wait states is allowed. It presents each instruction to the decode FSM through a valid/ready pair. It supports branch redirect, halt, and a fetch-timeout error.

## Interface
Parameters:
- AW, 9: PC and memory address width.
- DW, 16: instruction width.
- RESET_PC, 0: PC value loaded on reset, AW bits.
- MAX_WAIT, 15: maximum wait cycles per fetch before error; range 1..255.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset; 0 = reset asserted.
- mem_cmd  out  2  Memory command: MNONE=00, MREAD=01. MWRITE=10 is never driven by this block.
- mem_addr  out  AW  Fetch address; equals pc_out whenever mem_cmd=MREAD.
- mem_rdata  in  DW  Read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  Read complete. Ignored unless mem_cmd=MREAD.
- instr  out  DW  Instruction register contents.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  Decoder accepts instr this cycle.
- redirect  in  1  Load redirect_pc and discard any in-flight or held instruction.
- redirect_pc  in  AW  Target address for redirect.
- halt  in  1  Level. Sampled only at instruction acceptance.
- pc_out  out  AW  Address of the next instruction to fetch.
- halted  out  1  Block is in HALT.
- fetch_err  out  1  Sticky timeout flag.

## Operation
- States: RST, FETCH, HOLD, HALT.
- RST: mem_cmd=MNONE. On the first clock edge after reset deasserts, go to FETCH.
- FETCH: mem_cmd=MREAD, mem_addr=pc_out, wait_cnt increments each cycle.
  - mem_ready=1: ir<=mem_rdata; pc<=pc+1, wrapping modulo 2^AW; wait_cnt<=0; go to HOLD.
  - mem_ready=0 and wait_cnt=MAX_WAIT: fetch_err<=1; go to HALT; pc is unchanged.
- HOLD: instr_valid=1, mem_cmd=MNONE.
  - instr_ready=1 and halt=0: go to FETCH.
  - instr_ready=1 and halt=1: go to HALT.
  - Otherwise stay in HOLD; instr is held stable.
- HALT: mem_cmd=MNONE, halted=1. Leave only via redirect.
- redirect=1 in FETCH, HOLD or HALT:
  - pc<=redirect_pc, wait_cnt<=0, fetch_err<=0, next state FETCH.
  - redirect has priority over mem_ready, instr_ready, halt and timeout.
  - A held instruction is discarded even if instr_ready=1 in the same cycle.
- redirect is ignored in RST.
- Reset mid-fetch: all state returns immediately to reset values. A pending memory read is abandoned; mem_rdata is not captured.

## Timing
- Reset values: state=RST, pc_out=RESET_PC, instr=0, instr_valid=0, mem_cmd=MNONE, halted=0, fetch_err=0, wait_cnt=0.
- Zero-wait memory with instr_ready tied high: 2 cycles per instruction (FETCH, HOLD). The first MREAD is one cycle after reset deasserts.
- Each memory wait state adds exactly one FETCH cycle.
- Timeout: with mem_ready held low, fetch_err rises on the edge ending the (MAX_WAIT+1)th FETCH cycle.
- instr_valid and instr are registered and change only on clock edges.
- pc_out updates on the same edge that captures instr.
- Redirect takes effect on the next edge; MREAD to redirect_pc appears the following cycle.
- All outputs are Moore-decoded from registered state. There is no combinational path from any input to any output.

## Structure
- Shared package cpu_pkg:
  - MNONE/MREAD/MWRITE encodings.
  - fetch_state_t enum: RST, FETCH, HOLD, HALT.
  - Default RESET_PC constant.
- Sub-module fetch_pc_reg, parametrised by AW and RESET_PC:
  - Async active-low reset.
  - Load-enable register with an increment/redirect select mux.
- The FSM, instruction register and wait counter live in fetch_unit. wait_cnt is 8 bits.

## Test plan
- Reset release, AW=9, RESET_PC=0, zero-wait memory returning 16'hC0A5, instr_ready=1 -> MREAD at addr 0 in cycle 1, instr=16'hC0A5 with instr_valid in cycle 2, MREAD at addr 1 in cycle 3.
- mem_ready delayed 3 cycles -> FETCH holds addr stable for 4 cycles, pc_out increments once, and no extra MREAD is issued.
- instr_ready=0 for 5 cycles in HOLD -> instr stable, mem_cmd=MNONE throughout; accept on cycle 6 -> FETCH next.
- pc_out=9'h1FF fetch completes -> pc_out wraps to 0. Redirect to 9'h040 asserted in the same cycle as instr_ready in HOLD -> instruction dropped, next MREAD at 9'h040.
- halt=1 at acceptance -> halted=1, no MREAD for 10 cycles; redirect to 9'h010 -> halted=0 and MREAD at 9'h010.
- MAX_WAIT=4, mem_ready held 0 -> fetch_err=1 and HALT after 5 FETCH cycles. Reset asserted mid-fetch -> all outputs return to reset values immediately, asynchronously.
